// File: rtl/snespad_events.sv
// rtl/snespad_events.sv - SNES pad debouncer with press/release event FIFO
//
// Debounces each tracked pad button over consecutive accepted samples.
// After every accepted sample, a 16-cycle scan pushes one event per button
// that flipped into a show-ahead FIFO.
//
// Ports:
//   clk_i        clock
//   rstn_i       asynchronous active-low reset
//   pad_data_i   sampled pad word, active-low buttons (bit 15 = B ... bit 4 = R)
//   pad_valid_i  one-cycle strobe for pad_data_i; ignored while busy_o is high
//   buttons_o    debounced button state, active-high
//   busy_o       scan in progress
//   ev_valid_o   FIFO head valid
//   ev_ready_i   consumer accepts the head
//   ev_data_o    {pressed, index[3:0]}
//   overflow_o   sticky lost-event flag
//   ovf_clr_i    clears overflow_o (a same-cycle drop wins)
module snespad_events #(
    parameter int          DEBOUNCE   = 3,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] BTN_MASK   = 16'hFFF0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [15:0] pad_data_i,
    input  logic        pad_valid_i,
    output logic [15:0] buttons_o,
    output logic        busy_o,
    output logic        ev_valid_o,
    input  logic        ev_ready_i,
    output logic [4:0]  ev_data_o,
    output logic        overflow_o,
    input  logic        ovf_clr_i
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [15:0] change;
    logic [CW-1:0] cnt [16];
    logic        accept;
    logic        push;
    logic        scan_done;
    logic [4:0]  push_data;

    assign accept    = pad_valid_i && (state == S_IDLE);
    assign busy_o    = (state == S_SCAN);
    assign push_data = {buttons_o[idx], idx};

    // Scanner: walks idx 15 down to 0, one bit per cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= S_IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        push      = 1'b0;
        scan_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SCAN;
                    idx_nxt   = 4'd15;
                end
            end
            S_SCAN: begin
                push    = change[idx];
                idx_nxt = idx - 4'd1;
                if (idx == 4'd0) begin
                    state_nxt = S_IDLE;
                    scan_done = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Debounce: a disagreeing sample bumps the counter; DEBOUNCE in a row
    // flips the button and flags it for the scan. Any agreeing sample restarts.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            buttons_o <= 16'h0000;
            change    <= 16'h0000;
            for (int i = 0; i < 16; i++) cnt[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) begin
                if (BTN_MASK[i]) begin
                    // pad bit is active-low, so differing from buttons_o means agreement
                    if (pad_data_i[i] != buttons_o[i]) begin
                        cnt[i]    <= '0;
                        change[i] <= 1'b0;
                    end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
                        buttons_o[i] <= ~pad_data_i[i];
                        cnt[i]       <= '0;
                        change[i]    <= 1'b1;
                    end else begin
                        cnt[i]    <= cnt[i] + CW'(1);
                        change[i] <= 1'b0;
                    end
                end
            end
        end else if (scan_done) begin
            change <= 16'h0000;
        end
    end

    // Event FIFO with one extra pointer bit to tell full from empty.
    logic [4:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, push_ok, drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = ev_valid_o && ev_ready_i;
    // A full FIFO still takes the push when the head leaves the same cycle.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    assign ev_valid_o = !empty;
    assign ev_data_o  = empty ? 5'd0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overflow_o <= 1'b1;
            else if (ovf_clr_i)
                overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snespad_events.sv
// tb/tb_snespad_events.sv - self-checking bench for snespad_events
module tb_snespad_events;

    localparam int          DEPTH = 8;
    localparam logic [15:0] MASK  = 16'hFFF0;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] pad_data = 16'hFFFF;
    logic        pad_valid = 1'b0;
    logic        ev_ready = 1'b0;
    logic        ovf_clr = 1'b0;

    logic [15:0] d_btn [2];
    logic        d_busy [2];
    logic        d_evv [2];
    logic [4:0]  d_evd [2];
    logic        d_ovf [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // instance 0: DEBOUNCE = 3, instance 1: DEBOUNCE = 1
    snespad_events #(.DEBOUNCE(3), .FIFO_DEPTH(DEPTH), .BTN_MASK(MASK)) u_a (
        .clk_i(clk), .rstn_i(rstn), .pad_data_i(pad_data), .pad_valid_i(pad_valid),
        .buttons_o(d_btn[0]), .busy_o(d_busy[0]), .ev_valid_o(d_evv[0]),
        .ev_ready_i(ev_ready), .ev_data_o(d_evd[0]), .overflow_o(d_ovf[0]),
        .ovf_clr_i(ovf_clr));

    snespad_events #(.DEBOUNCE(1), .FIFO_DEPTH(DEPTH), .BTN_MASK(MASK)) u_b (
        .clk_i(clk), .rstn_i(rstn), .pad_data_i(pad_data), .pad_valid_i(pad_valid),
        .buttons_o(d_btn[1]), .busy_o(d_busy[1]), .ev_valid_o(d_evv[1]),
        .ev_ready_i(ev_ready), .ev_data_o(d_evd[1]), .overflow_o(d_ovf[1]),
        .ovf_clr_i(ovf_clr));

    function automatic void chk(string name, int m, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0h expected=%0h t=%0t", name, m, act, exp, $time);
        end
    endfunction

    // Reference model: scan_t counts scan cycles (1..16, 0 = idle); the bit
    // examined in scan cycle t is 16 - t. FIFO is a plain ring of entries.
    logic [15:0] m_btn [2];
    int          m_cnt [2][16];
    logic [15:0] m_pend [2];
    int          m_t [2];
    logic [4:0]  m_buf [2][DEPTH];
    int          m_head [2];
    int          m_n [2];
    logic        m_ovf [2];

    function automatic int deb(int m);
        return (m == 0) ? 3 : 1;
    endfunction

    task automatic model_reset(input int m);
        m_btn[m] = 16'h0; m_pend[m] = 16'h0; m_t[m] = 0;
        m_head[m] = 0; m_n[m] = 0; m_ovf[m] = 1'b0;
        for (int i = 0; i < 16; i++) m_cnt[m][i] = 0;
    endtask

    task automatic model_step(input int m);
        bit pop, push, drop, pressed;
        logic [4:0] ev;
        int k;
        pop  = (m_n[m] > 0) && ev_ready;
        push = 1'b0;
        ev   = 5'd0;
        if (m_t[m] > 0) begin
            k = 16 - m_t[m];
            if (m_pend[m][k]) begin
                push = 1'b1;
                ev = {m_btn[m][k], 4'(k)};
            end
        end
        drop = push && (m_n[m] == DEPTH) && !pop;
        if (pop) begin
            m_head[m] = (m_head[m] + 1) % DEPTH;
            m_n[m]--;
        end
        if (push && !drop) begin
            m_buf[m][(m_head[m] + m_n[m]) % DEPTH] = ev;
            m_n[m]++;
        end
        if (drop) m_ovf[m] = 1'b1;
        else if (ovf_clr) m_ovf[m] = 1'b0;
        if (m_t[m] > 0) begin
            m_t[m] = (m_t[m] == 16) ? 0 : m_t[m] + 1;
        end else if (pad_valid) begin
            m_pend[m] = 16'h0;
            for (int i = 0; i < 16; i++) begin
                if (MASK[i]) begin
                    pressed = !pad_data[i];
                    if (pressed == m_btn[m][i]) m_cnt[m][i] = 0;
                    else begin
                        m_cnt[m][i]++;
                        if (m_cnt[m][i] == deb(m)) begin
                            m_btn[m][i] = pressed;
                            m_cnt[m][i] = 0;
                            m_pend[m][i] = 1'b1;
                        end
                    end
                end
            end
            m_t[m] = 1;
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    // Compare process
    logic seen_a = 1'b0;
    logic seen_b = 1'b0;
    always @(negedge clk) begin
        if (d_evv[0] === 1'b1) seen_a = 1'b1;
        if (d_evv[1] === 1'b1) seen_b = 1'b1;
        if (rstn) begin
            for (int m = 0; m < 2; m++) begin
                chk("buttons",  m, d_btn[m],  m_btn[m]);
                chk("busy",     m, d_busy[m], m_t[m] != 0);
                chk("ev_valid", m, d_evv[m],  m_n[m] > 0);
                chk("ev_data",  m, d_evd[m],  (m_n[m] > 0) ? m_buf[m][m_head[m]] : 5'd0);
                chk("overflow", m, d_ovf[m],  m_ovf[m]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] w);
        pad_data  = w;
        pad_valid = 1'b1;
        @(negedge clk);
        pad_valid = 1'b0;
    endtask

    initial begin
        cyc(3);
        for (int m = 0; m < 2; m++) begin
            chk("rst_buttons", m, d_btn[m], 16'h0);
            chk("rst_busy",    m, d_busy[m], 1'b0);
            chk("rst_ev_valid", m, d_evv[m], 1'b0);
            chk("rst_ev_data", m, d_evd[m], 5'd0);
            chk("rst_overflow", m, d_ovf[m], 1'b0);
        end
        rstn = 1'b1;
        cyc(2);

        // B held for three samples flips the DEBOUNCE=3 instance once
        ev_ready = 1'b0;
        strobe(16'h7FFF); cyc(19);
        strobe(16'h7FFF); cyc(19);
        chk("d3_btn15_before", 0, d_btn[0][15], 1'b0);
        strobe(16'h7FFF);
        chk("d3_btn15_after", 0, d_btn[0][15], 1'b1);
        cyc(1);
        chk("d3_ev_valid", 0, d_evv[0], 1'b1);
        chk("d3_ev_data", 0, d_evd[0], 5'b1_1111);
        cyc(20);
        chk("d3_ev_hold", 0, d_evd[0], 5'b1_1111);
        ev_ready = 1'b1;
        cyc(1);
        chk("d3_one_event", 0, d_evv[0], 1'b0);
        for (int s = 0; s < 3; s++) begin strobe(16'hFFFF); cyc(19); end

        // alternating samples never reach the DEBOUNCE=3 threshold
        seen_a = 1'b0;
        for (int s = 0; s < 6; s++) begin
            strobe((s % 2 == 0) ? 16'h7FFF : 16'hFFFF); cyc(19);
        end
        chk("d3_alt_no_event", 0, seen_a, 1'b0);
        chk("d3_alt_buttons", 0, d_btn[0], 16'h0);

        // A + Start on DEBOUNCE=1: descending order
        ev_ready = 1'b0;
        strobe(16'hEF7F); cyc(17);
        chk("d1_press_first", 1, d_evd[1], 5'b1_1100);
        ev_ready = 1'b1; cyc(1); ev_ready = 1'b0;
        chk("d1_press_second", 1, d_evd[1], 5'b1_0111);
        ev_ready = 1'b1; cyc(1);
        chk("d1_press_drained", 1, d_evv[1], 1'b0);
        ev_ready = 1'b0;
        strobe(16'hFFFF); cyc(17);
        chk("d1_rel_first", 1, d_evd[1], 5'b0_1100);
        ev_ready = 1'b1; cyc(1); ev_ready = 1'b0;
        chk("d1_rel_second", 1, d_evd[1], 5'b0_0111);
        ev_ready = 1'b1; cyc(2);

        // strobe during a scan is dropped; masked bit 3 never reports
        seen_b = 1'b0;
        strobe(16'hFFFF); cyc(4);
        chk("busy_mid_scan", 1, d_busy[1], 1'b1);
        strobe(16'h0000); cyc(16);
        chk("busy_strobe_ignored", 1, d_btn[1], 16'h0);
        strobe(16'hFFF7); cyc(18);
        chk("masked_no_event", 1, seen_b, 1'b0);
        chk("masked_buttons", 1, d_btn[1], 16'h0);

        // overflow: 12 presses into 8 slots
        ev_ready = 1'b0;
        strobe(16'h0000); cyc(18);
        chk("ovf_set", 1, d_ovf[1], 1'b1);
        chk("ovf_full_valid", 1, d_evv[1], 1'b1);
        ev_ready = 1'b1;
        for (int k = 15; k >= 8; k--) begin
            chk("ovf_pop_order", 1, d_evd[1], {1'b1, 4'(k)});
            cyc(1);
        end
        chk("ovf_drained", 1, d_evv[1], 1'b0);
        chk("ovf_sticky", 1, d_ovf[1], 1'b1);
        ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
        chk("ovf_cleared", 1, d_ovf[1], 1'b0);

        // asynchronous reset in the middle of a scan
        ev_ready = 1'b0;
        strobe(16'hFFFF); cyc(4);
        chk("pre_rst_busy", 1, d_busy[1], 1'b1);
        chk("pre_rst_valid", 1, d_evv[1], 1'b1);
        rstn = 1'b0;
        #1;
        chk("arst_ev_valid", 1, d_evv[1], 1'b0);
        chk("arst_buttons", 1, d_btn[1], 16'h0);
        chk("arst_busy", 1, d_busy[1], 1'b0);
        chk("arst_busy_a", 0, d_busy[0], 1'b0);
        ev_ready = 1'b1;
        cyc(2);
        rstn = 1'b1;
        cyc(2);

        // randomized traffic against the model
        for (int c = 0; c < 5000; c++) begin
            int r;
            bit stall;
            stall = ((c / 400) % 3) == 2;
            r = $urandom_range(0, 3);
            if (r == 0) pad_data = 16'($urandom);
            else if (r == 1) pad_data = pad_data ^ (16'h1 << $urandom_range(0, 15));
            pad_valid = ($urandom_range(0, 2) == 0);
            ev_ready  = stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 31) == 0);
            rstn      = ($urandom_range(0, 1499) != 0);
            @(negedge clk);
        end
        pad_valid = 1'b0;
        ovf_clr   = 1'b0;
        rstn      = 1'b1;
        ev_ready  = 1'b1;
        cyc(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
